// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detector path.
//   - Default parameter values for the controller and its matcher.
//   - Power-up detection pattern.
//   - Controller state encoding.
package seq_detect_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_CNT_W  = 8;

  localparam logic [3:0] DEF_PATTERN = 4'b1010;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/seq_pattern_matcher.sv
// Serial pattern matcher.
// Shifts one bit per enabled cycle into a PAT_W-bit history and raises a
// registered one-cycle match pulse in the cycle after the shift that
// completes the pattern. Overlapping matches are detected naturally because
// the history is never flushed on a hit.
//
// Ports:
//   clk      in   clock, rising edge
//   resetn   in   synchronous active-low reset
//   clear    in   clears history, fill level and any pending pulse
//   shift_en in   shift bit_in into the history this cycle
//   bit_in   in   serial data bit
//   pattern  in   PAT_W-bit pattern to compare against
//   match    out  one-cycle pulse per detection
module seq_pattern_matcher
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int              FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    hist_nxt = PAT_W'({hist, bit_in});
    fill_nxt = (fill == FULL) ? fill : fill + FILL_W'(1);
  end

  // Fill guards against matching on zero-padding before PAT_W bits arrived.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= shift_en && (hist_nxt == pattern) && (fill_nxt == FULL);
      if (shift_en) begin
        hist <= hist_nxt;
        fill <= fill_nxt;
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Streaming controller for the serial pattern detector path.
// Accepts DATA_W-bit words over valid/ready, serializes them one bit per
// clock into seq_pattern_matcher, counts detections (saturating) and raises
// a sticky interrupt when the count reaches a programmable threshold.
// A new word can be accepted during the last bit of the current one, so a
// continuous stream has no bubbles.
//
// Build option: SEQDET_LSB_FIRST_EN -- when defined, words serialize LSB
// first; otherwise MSB first. Latency is identical either way.
//
// Ports:
//   clk, resetn         clock and synchronous active-low reset
//   enable              allows acceptance of new words
//   in_data/in_valid    word source; in_ready accepts the word
//   cfg_load            latch cfg_pattern/cfg_threshold, clear history/count/irq
//   cfg_pattern         pattern to detect
//   cfg_threshold       match count that sets irq (0 disables)
//   irq_clr             clears irq
//   busy                a word is being serialized
//   match_pulse         one-cycle pulse per detection
//   match_count         saturating detection count
//   irq                 sticky threshold interrupt
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              cfg_load,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [CNT_W-1:0]  cfg_threshold,
  input  logic              irq_clr,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              irq
);

  localparam logic [0:0]        ST_IDLE  = IDLE;
  localparam logic [0:0]        ST_SHIFT = SHIFT;
  localparam int                IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

  logic [0:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic [PAT_W-1:0]  pattern_q;
  logic [CNT_W-1:0]  threshold_q;

  logic last_bit;
  logic accept;
  logic shift_en;
  logic bit_out;
  logic cfg_take;
  logic cnt_inc;
  logic irq_set;

  always_comb begin
    last_bit = (state == ST_SHIFT) && (bit_idx == LAST_IDX);
    // Held low during reset so the source never sees a phantom accept.
    in_ready = resetn && enable && ((state == ST_IDLE) || last_bit);
    accept   = in_valid && in_ready;
    shift_en = (state == ST_SHIFT);
    busy     = shift_en;
    // Config changes only between words so a word is never split across patterns.
    cfg_take = cfg_load && !busy && !accept;
    cnt_inc  = match_pulse && !(&match_count);
    irq_set  = cnt_inc && (threshold_q != '0) &&
               ((match_count + CNT_W'(1)) == threshold_q);
  end

`ifdef SEQDET_LSB_FIRST_EN
  assign bit_out = shreg[0];
`else
  assign bit_out = shreg[DATA_W-1];
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
    end else if (accept) begin
      // On a back-to-back accept the last bit of the old word is still
      // presented to the matcher this cycle via bit_out.
      shreg   <= in_data;
      bit_idx <= '0;
      state   <= ST_SHIFT;
    end else if (shift_en) begin
`ifdef SEQDET_LSB_FIRST_EN
      shreg   <= shreg >> 1;
`else
      shreg   <= shreg << 1;
`endif
      bit_idx <= bit_idx + IDX_W'(1);
      if (last_bit) state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pattern_q   <= PAT_W'(DEF_PATTERN);
      threshold_q <= '0;
      match_count <= '0;
      irq         <= 1'b0;
    end else if (cfg_take) begin
      pattern_q   <= cfg_pattern;
      threshold_q <= cfg_threshold;
      match_count <= '0;
      irq         <= 1'b0;
    end else begin
      if (cnt_inc) match_count <= match_count + CNT_W'(1);
      // A threshold hit in the same cycle as irq_clr keeps irq asserted.
      if (irq_set)      irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

  seq_pattern_matcher #(
    .PAT_W (PAT_W)
  ) u_matcher (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (cfg_take),
    .shift_en (shift_en),
    .bit_in   (bit_out),
    .pattern  (pattern_q),
    .match    (match_pulse)
  );

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed words with hand-computed hit maps.
// Each hit map lists, in shift order (leftmost = first bit), which bits of a
// word complete the pattern. Expected pulse cycles and counts go into a
// queue; a monitor pops and compares whenever match_pulse is seen.
module tb_seq_detect_ctrl;

  localparam int DATA_W = 8;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic              enable;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cfg_load;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [CNT_W-1:0]  cfg_threshold;
  logic              irq_clr;
  logic              busy;
  logic              match_pulse;
  logic [CNT_W-1:0]  match_count;
  logic              irq;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   exp_count = 0;
  bit   cnt_pend  = 1'b0;
  int   pend_cnt  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_detect_ctrl #(
    .DATA_W (DATA_W),
    .PAT_W  (PAT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .cfg_load      (cfg_load),
    .cfg_pattern   (cfg_pattern),
    .cfg_threshold (cfg_threshold),
    .irq_clr       (irq_clr),
    .busy          (busy),
    .match_pulse   (match_pulse),
    .match_count   (match_count),
    .irq           (irq)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every observed pulse against the queue head and the
  // count one cycle later.
  always @(negedge clk) begin
    if (cnt_pend) begin
      check("count_after_match", match_count, pend_cnt);
      cnt_pend = 1'b0;
    end
    if (match_pulse === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_match", match_pulse, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("match_cycle", cyc, e.cyc);
        pend_cnt = e.cnt;
        cnt_pend = 1'b1;
      end
    end
  end

  // Presents a word, waits (bounded) for the handshake, and queues the
  // expected pulses. Returns at handshake edge + 1 time unit.
  task automatic send_word(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] hits,
                           output int base);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("handshake_timeout", in_ready, 1);
      in_valid = 1'b0;
      base = -1;
      return;
    end
    @(posedge clk);
    #1;
    base     = cyc;
    in_valid = 1'b0;
    for (int k = 1; k <= DATA_W; k++) begin
      if (hits[DATA_W-k]) begin
        if (exp_count < 255) exp_count++;
        sb_q.push_back('{cyc: base + k, cnt: exp_count});
      end
    end
  endtask

  task automatic cfg(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] t, input bit honoured);
    cfg_pattern   = p;
    cfg_threshold = t;
    cfg_load      = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    if (honoured) exp_count = 0;
  endtask

  task automatic idle_wait();
    repeat (DATA_W + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int b0, b1;
    resetn        = 1'b0;
    enable        = 1'b1;
    in_data       = '0;
    in_valid      = 1'b0;
    cfg_load      = 1'b0;
    cfg_pattern   = '0;
    cfg_threshold = '0;
    irq_clr       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_match_pulse", match_pulse, 0);
    check("reset_match_count", match_count, 0);
    check("reset_irq", irq, 0);
    resetn = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1);
    enable = 1'b0;
    #1;
    check("disabled_in_ready", in_ready, 0);
    enable = 1'b1;
    @(posedge clk);
    #1;

    // Default pattern 1010 on 8'hAA: hits on bits 4, 6, 8.
    send_word(8'hAA, 8'b0001_0101, b0);
    check("t1_busy", busy, 1);
    check("t1_in_ready_mid", in_ready, 0);
    idle_wait();
    check("t1_count", match_count, 3);
    check("t1_irq", irq, 0);

    // Word-spanning match: 05 then 00 -> only the first bit of 00 hits.
    cfg(4'b1010, 8'd0, 1'b1);
    send_word(8'h05, 8'b0000_0000, b0);
    send_word(8'h00, 8'b1000_0000, b1);
    idle_wait();
    check("t2_count", match_count, 1);

    // Back-to-back AA AA: no bubble, 7 matches.
    cfg(4'b1010, 8'd0, 1'b1);
    send_word(8'hAA, 8'b0001_0101, b0);
    send_word(8'hAA, 8'b0101_0101, b1);
    check("t3_no_bubble", b1 - b0, DATA_W);
    check("t3_busy_second", busy, 1);
    idle_wait();
    check("t3_count", match_count, 7);
    check("t3_idle_busy", busy, 0);

    // Pattern 1111, threshold 2, word FF: hits on bits 4..8.
    cfg(4'b1111, 8'd2, 1'b1);
    send_word(8'hFF, 8'b0001_1111, b0);
    repeat (5) @(posedge clk);
    #1;
    check("t4_irq_before", irq, 0);
    irq_clr = 1'b1;          // coincides with the set
    @(posedge clk);
    #1;
    irq_clr = 1'b0;
    check("t4_irq_set_wins", irq, 1);
    check("t4_count_at_set", match_count, 2);
    @(posedge clk);
    #1;
    irq_clr = 1'b1;
    @(posedge clk);
    #1;
    irq_clr = 1'b0;
    check("t4_irq_cleared", irq, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_irq_stays_clear", irq, 0);
    check("t4_count", match_count, 5);

    // Reset at bit 3 of AA aborts the word; fresh 0A then hits once.
    cfg(4'b1010, 8'd0, 1'b1);
    send_word(8'hAA, 8'b0000_0000, b0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("t5_busy_after_reset", busy, 0);
    check("t5_count_after_reset", match_count, 0);
    resetn    = 1'b1;
    exp_count = 0;
    idle_wait();
    check("t5_no_pulses_count", match_count, 0);
    send_word(8'h0A, 8'b0000_0001, b0);
    idle_wait();
    check("t5_count", match_count, 1);
    check("t5_irq", irq, 0);

    // cfg_load while busy is ignored: pattern stays 1010, count keeps running.
    cfg(4'b1010, 8'd0, 1'b1);
    send_word(8'hAA, 8'b0001_0101, b0);
    @(posedge clk);
    #1;
    cfg(4'b1111, 8'd1, 1'b0);
    idle_wait();
    check("t6_count", match_count, 3);
    check("t6_irq", irq, 0);
    send_word(8'h0F, 8'b0000_0000, b0);  // would hit with 1111
    idle_wait();
    check("t6_pattern_kept", match_count, 3);

    // Saturation: 3 + 64*4 = 259 matches, count holds at 255.
    cfg(4'b1010, 8'd0, 1'b1);
    send_word(8'hAA, 8'b0001_0101, b0);
    for (int w = 0; w < 64; w++) send_word(8'hAA, 8'b0101_0101, b0);
    idle_wait();
    check("t7_saturated", match_count, 255);
    check("t7_irq", irq, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Streaming controller for the serial pattern detector path.
- Accepts parallel words over a valid/ready handshake and serializes them one bit per clock into a pattern matcher.
- The matcher detects a programmable PAT_W-bit pattern, with overlapping matches and matches that span word boundaries.
- Counts detections and raises a sticky interrupt at a programmable threshold; sits between the bus-side word source and the detection consumer.

Parameters:
- DATA_W, 8, width of each input word (bits serialized per word).
- PAT_W, 4, pattern length in bits.
- CNT_W, 8, width of the match counter and threshold.

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  reset, synchronous, active-low.
- enable  input  1  allows acceptance of new words.
- in_data  input  DATA_W  word to serialize.
- in_valid  input  1  in_data valid.
- in_ready  output  1  controller accepts in_data this cycle.
- cfg_load  input  1  pulse: latch cfg_pattern/cfg_threshold, clear history/count/irq.
- cfg_pattern  input  PAT_W  pattern to detect.
- cfg_threshold  input  CNT_W  match count that sets irq; 0 disables irq.
- irq_clr  input  1  clears irq.
- busy  output  1  a word is being serialized.
- match_pulse  output  1  one-cycle pulse per detected pattern.
- match_count  output  CNT_W  saturating detection count.
- irq  output  1  sticky threshold interrupt.

Behaviour:
- Reset is synchronous and active-low: clk is the single clock, and resetn is sampled on its rising edge.
- Reset values:
  - state=IDLE; in_ready=0 while resetn=0; busy=0; match_pulse=0; match_count=0; irq=0.
  - History cleared, with fill=0.
  - pattern=DEF_PATTERN (4'b1010); threshold=0.
- FSM states:
  - IDLE: in_ready=enable. Handshake (in_valid&in_ready) latches in_data into the shift register, sets bit_idx=0 and goes to SHIFT.
  - SHIFT: each cycle shifts one bit, MSB first, into the matcher, then increments bit_idx.
    - On bit_idx==DATA_W-1, in_ready=enable. If a handshake occurs, the next word loads with no bubble and the FSM stays in SHIFT; otherwise it returns to IDLE.
- busy=1 in SHIFT.
- Latency: a word accepted at edge N has its MSB shifted at edge N+1 and its LSB at edge N+DATA_W.
- Matcher:
  - On each shift, hist <= {hist[PAT_W-2:0], bit} and fill saturates at PAT_W.
  - match_pulse is registered: it is 1 in the cycle after a shift where the new hist==pattern and the new fill==PAT_W.
  - History persists across words, so overlapping and word-spanning matches count.
- match_count increments on each match and saturates at 2^CNT_W-1.
- irq:
  - Set when an increment makes match_count==threshold, with threshold!=0.
  - Cleared by irq_clr; a set in the same cycle as irq_clr wins.
- cfg_load:
  - Honoured only when busy=0 and no handshake occurs that cycle; ignored otherwise.
  - Latches the config, clears hist, fill, match_count and irq, and takes effect from the next cycle.
- If enable deasserts mid-word, the current word completes and no new word is accepted.
- Reset mid-word aborts serialization immediately; the partial word is discarded and the history is cleared.
- in_data is sampled only at the handshake; changes while busy are ignored.

Optional Feature:
- Macro SEQDET_LSB_FIRST_EN.
- Defined: words serialize LSB first; the latency figures are unchanged.
- Undefined: MSB first, as specified above.

Decomposition:
- Package seq_detect_pkg holds:
  - State enum {IDLE, SHIFT}.
  - DEF_PATTERN = 4'b1010.
  - Default parameter constants.
- Sub-module seq_pattern_matcher contains the hist shift register, fill counter, comparator and registered match_pulse.
  - Its inputs are clk, resetn, clear, shift_en, bit_in and pattern; its output is match.

Test Plan:
- Reset, default pattern, threshold=0, one word 8'hAA -> match_pulse at 3 cycles (bits 4, 6, 8), match_count=3, irq stays 0.
- 8'h05 then 8'h00 -> exactly one match, in the cycle after the first bit of the second word (spanning); match_count=1.
- Continuous in_valid with 8'hAA, 8'hAA -> in_ready high on the load cycle and on the last-bit cycle, 16 consecutive shift cycles with no bubble, match_count=7 (the 0 of "10|10" spans words).
- cfg_load with pattern 4'b1111 and threshold=2, then word 8'hFF -> matches on bits 4 through 8 (5 pulses); irq rises when the count reaches 2. irq_clr on that same cycle leaves irq=1; a later irq_clr clears it, and irq does not re-set as the count grows.
- Assert resetn=0 for one edge at bit 3 of 8'hAA -> busy=0, no further pulses, match_count=0; the next word 8'h0A -> match_count=1.
- cfg_load pulsed while busy=1 -> ignored (pattern and count unchanged); counter saturation: threshold=0, feed 8'hAA words past 255 matches -> match_count holds at 255.
